// File: rtl/display_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display with frame-synchronous shadow loading.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 is always shown).
module display_scan_ctrl #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    input  logic        update_req,
    output logic        update_ack,
    output logic [7:0]  digitselect,
    output logic [7:0]  segments,
    output logic        frame_done
);
    localparam int TW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_CYCLES - 1);
    localparam logic [31:0] BLANK_U = BLANK_CYCLES;

    logic [TW-1:0] r_tick;
    logic [2:0]    r_digit;
    logic [31:0]   r_val;
    logic [7:0]    r_dp;
    logic [7:0]    r_en;

    logic       w_tick_wrap;
    logic       w_frame_end;
    logic       w_lit;
    logic [3:0] w_nibble;
    logic [6:0] w_hex;
`ifdef LEADING_ZERO_BLANK_EN
    logic       w_upper_zero;
`endif

    always_comb begin
        w_tick_wrap = (r_tick == TICK_LAST);
        w_frame_end = w_tick_wrap && (r_digit == 3'd7);
        w_nibble    = r_val[{r_digit, 2'b00} +: 4];
    end

    always_comb begin
        w_lit = r_en[r_digit] && (32'(r_tick) >= BLANK_U);
`ifdef LEADING_ZERO_BLANK_EN
        // Suppress digit d>0 when it and every more-significant nibble are zero and its dp is off.
        w_upper_zero = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k >= 32'(r_digit) && r_val[4*k +: 4] != 4'h0)
                w_upper_zero = 1'b0;
        end
        if (r_digit != 3'd0 && w_upper_zero && !r_dp[r_digit])
            w_lit = 1'b0;
`endif
    end

    always_comb begin
        case (w_nibble)
            4'h0:    w_hex = 7'b1111110;
            4'h1:    w_hex = 7'b0110000;
            4'h2:    w_hex = 7'b1101101;
            4'h3:    w_hex = 7'b1111001;
            4'h4:    w_hex = 7'b0110011;
            4'h5:    w_hex = 7'b1011011;
            4'h6:    w_hex = 7'b1011111;
            4'h7:    w_hex = 7'b1110000;
            4'h8:    w_hex = 7'b1111111;
            4'h9:    w_hex = 7'b1111011;
            4'hA:    w_hex = 7'b1110111;
            4'hB:    w_hex = 7'b0011111;
            4'hC:    w_hex = 7'b1001110;
            4'hD:    w_hex = 7'b0111101;
            4'hE:    w_hex = 7'b1001111;
            default: w_hex = 7'b1000111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tick      <= '0;
            r_digit     <= '0;
            r_val       <= '0;
            r_dp        <= '0;
            r_en        <= '0;
            update_ack  <= 1'b0;
            frame_done  <= 1'b0;
            digitselect <= '1;
            segments    <= '1;
        end else begin
            r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
            if (w_tick_wrap)
                r_digit <= r_digit + 1'b1;
            // Shadow loads only on the frame wrap so a frame never mixes old and new data.
            if (w_frame_end && update_req) begin
                r_val <= value;
                r_dp  <= dp;
                r_en  <= digit_en;
            end
            update_ack  <= w_frame_end && update_req;
            frame_done  <= w_frame_end;
            digitselect <= w_lit ? ~(8'b1 << r_digit) : '1;
            segments    <= w_lit ? ~{w_hex, r_dp[r_digit]} : '1;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position reference model.
module tb_display_scan_ctrl;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FRAME = 8 * DC;
    localparam logic [6:0] HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  digit_en = '0;
    logic        update_req = 1'b0;
    logic        update_ack;
    logic [7:0]  digitselect;
    logic [7:0]  segments;
    logic        frame_done;

    int n_checks = 0;
    int n_pass = 0;

    // Model: shadow contents plus the number of scan cycles since reset release.
    logic [31:0] m_val = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_en = '0;
    int          m_pos = 0;
    logic [7:0]  lit_mask;

    always #5 clk = ~clk;

    display_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .dp(dp), .digit_en(digit_en),
        .update_req(update_req), .update_ack(update_ack), .digitselect(digitselect),
        .segments(segments), .frame_done(frame_done));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        int t, d;
        logic lit, in_rst, e_ack, e_fd;
        logic [7:0] e_ds, e_seg;
        in_rst = !reset_n;
        e_ds = 8'hFF; e_seg = 8'hFF; e_ack = 1'b0; e_fd = 1'b0;
        if (!in_rst) begin
            t = m_pos % DC;
            d = (m_pos / DC) % 8;
            lit = (t >= BC) && m_en[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (m_val >> (4 * d)) == 32'd0 && !m_dp[d]) lit = 1'b0;
`endif
            if (lit) begin
                e_ds = ~(8'd1 << d);
                e_seg = ~{HEX[m_val[4*d +: 4]], m_dp[d]};
            end
            e_fd = (m_pos % FRAME) == FRAME - 1;
            e_ack = e_fd && update_req;
        end
        @(posedge clk);
        #1;
        if (in_rst) begin
            m_val = '0; m_dp = '0; m_en = '0; m_pos = 0;
        end else begin
            if (e_ack) begin
                m_val = value; m_dp = dp; m_en = digit_en;
            end
            m_pos++;
        end
        check("digitselect", 32'(digitselect), 32'(e_ds));
        check("segments", 32'(segments), 32'(e_seg));
        check("ack_fd", {30'd0, update_ack, frame_done}, {30'd0, e_ack, e_fd});
        lit_mask |= ~digitselect;
    endtask

    task automatic wait_ack(input string tag, output int cnt);
        cnt = 0;
        while (!update_ack && cnt < 200) begin
            step();
            cnt++;
        end
        if (!update_ack) check(tag, 32'd0, 32'd1);
        update_req = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) step();
        check("rst_ds", 32'(digitselect), 32'hFF);
        reset_n = 1'b1;
        repeat (200) step();

        // Known pattern: 0123ABCD, all enabled, dp on digit 0.
        value = 32'h0123_ABCD; digit_en = 8'hFF; dp = 8'h01; update_req = 1'b1;
        wait_ack("load1_timeout", cnt);
        check("ack_with_fd", 32'(frame_done), 32'd1);
        repeat (3) step();
        check("d0_sel", 32'(digitselect), 32'hFE);
        check("d0_seg", 32'(segments), 32'h84);
        repeat (8) step();
        check("d1_seg", 32'(segments), 32'h63);

        // Random data churn without requests, then held requests.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(5, 90)) begin
                value = $urandom; dp = 8'($urandom); digit_en = 8'($urandom);
                step();
            end
            value = $urandom; dp = 8'($urandom); digit_en = 8'($urandom);
            if (r % 3 == 0) value = value >> (4 * $urandom_range(1, 7));
            update_req = 1'b1;
            wait_ack("req_timeout", cnt);
            check("req_latency_ok", 32'(cnt <= FRAME + 1), 32'd1);
            repeat ($urandom_range(0, 70)) step();
        end

        // Reset during digit 5 with a request pending.
        cnt = 0;
        while (((m_pos / DC) % 8) != 5 && cnt < 200) begin step(); cnt++; end
        update_req = 1'b1;
        value = 32'hDEAD_BEEF; digit_en = 8'hFF; dp = 8'hA5;
        reset_n = 1'b0;
        step();
        check("mid_rst_ack", 32'(update_ack), 32'd0);
        reset_n = 1'b1;
        wait_ack("post_rst_timeout", cnt);
        check("post_rst_latency", 32'(cnt), 32'(FRAME));

        // Leading-zero case: only digits 0 and 1 light when blanking is built in.
        value = 32'h0000_00F0; digit_en = 8'hFF; dp = 8'h00; update_req = 1'b1;
        wait_ack("lz_timeout", cnt);
        lit_mask = '0;
        repeat (FRAME) step();
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_digits", 32'(lit_mask), 32'h03);
`else
        check("lz_digits", 32'(lit_mask), 32'hFF);
`endif
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
